// File: rtl/zap_fetch_queue.sv
// zap_fetch_queue: DEPTH-entry prefetch FIFO between the I-cache and decode.
// Optional BKPT-to-abort conversion is enabled by defining ZAP_FETCH_QUEUE_BKPT_EN.
module zap_fetch_queue #(
    parameter int DEPTH  = 4,
    parameter int PRED_W = 33
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_clear_from_writeback,
    input  logic                    i_data_stall,
    input  logic                    i_clear_from_alu,
    input  logic                    i_stall_from_pipe,
    input  logic                    i_clear_from_decode,
    input  logic [31:0]             i_pc_ff,
    input  logic                    i_cpsr_ff_t,
    input  logic [31:0]             i_instruction,
    input  logic                    i_valid,
    input  logic                    i_instr_abort,
    input  logic [PRED_W-1:0]       i_pred,
    output logic                    o_ready,
    output logic                    o_valid,
    output logic [31:0]             o_instruction,
    output logic                    o_instr_abort,
    output logic [31:0]             o_pc_ff,
    output logic [31:0]             o_pc_plus_8_ff,
    output logic [PRED_W-1:0]       o_pred,
    output logic [$clog2(DEPTH):0]  o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

`ifdef ZAP_FETCH_QUEUE_BKPT_EN
    function automatic logic arm_bkpt(input logic [31:0] w);
        return (w ==? 32'b????_0001_0010_????_????_????_0111_????);
    endfunction

    function automatic logic thumb_bkpt(input logic [15:0] h);
        return (h ==? 16'b1011_1110_????_????);
    endfunction
`endif

    logic [31:0]       mem_instr_r [DEPTH];
    logic              mem_abort_r [DEPTH];
    logic [31:0]       mem_pc_r    [DEPTH];
    logic [31:0]       mem_pcp_r   [DEPTH];
    logic [PRED_W-1:0] mem_pred_r  [DEPTH];

    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] wr_ptr_r;
    logic [CW-1:0] count_r;
    logic          sleep_r;

    logic          flush_s;
    logic          pop_s;
    logic          push_s;
    logic          valid_s;
    logic          ready_s;
    logic [31:0]   ent_instr_s;
    logic [31:0]   ent_pcp_s;
    logic          ent_abort_s;
    logic          bkpt_s;

    // Ready depends only on flops so the I-cache never sees a combinational path through the queue.
    assign valid_s = (count_r != CW'(0));
    assign ready_s = (count_r != CW'(DEPTH)) & ~sleep_r;

    // Flush / pop / push qualification; flush dominates every other action.
    always_comb begin
        flush_s = i_clear_from_writeback
                | (i_clear_from_alu & ~i_data_stall)
                | (i_clear_from_decode & ~i_data_stall & ~i_stall_from_pipe);
        pop_s   = valid_s & ~i_data_stall & ~i_stall_from_pipe & ~flush_s;
        push_s  = i_valid & ready_s & ~flush_s;
    end

    // Format the incoming word into an entry: halfword steering, PC+8/PC+4 and abort.
    always_comb begin
        ent_instr_s = i_instruction;
        ent_pcp_s   = i_pc_ff + 32'd8;
        bkpt_s      = 1'b0;
        if (i_pc_ff[1]) begin
            ent_instr_s = {16'h0000, i_instruction[31:16]};
        end else begin
            ent_instr_s = i_instruction;
        end
        if (i_cpsr_ff_t) begin
            ent_pcp_s = i_pc_ff + 32'd4;
        end else begin
            ent_pcp_s = i_pc_ff + 32'd8;
        end
`ifdef ZAP_FETCH_QUEUE_BKPT_EN
        if (i_cpsr_ff_t) begin
            bkpt_s = thumb_bkpt(i_pc_ff[1] ? i_instruction[31:16] : i_instruction[15:0]);
        end else begin
            bkpt_s = arm_bkpt(i_instruction);
        end
`endif
        ent_abort_s = i_instr_abort | bkpt_s;
    end

    // Pointer, occupancy and sleep state.
    always_ff @(posedge i_clk) begin
        if (i_reset || flush_s) begin
            rd_ptr_r <= PW'(0);
            wr_ptr_r <= PW'(0);
            count_r  <= CW'(0);
            sleep_r  <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            if (push_s && !pop_s) begin
                count_r <= count_r + CW'(1);
            end else if (pop_s && !push_s) begin
                count_r <= count_r - CW'(1);
            end
            if (push_s && ent_abort_s) begin
                sleep_r <= 1'b1;
            end
        end
    end

    // Entry storage; contents are masked on the outputs whenever the queue is empty.
    always_ff @(posedge i_clk) begin
        if (push_s) begin
            mem_instr_r[wr_ptr_r] <= ent_instr_s;
            mem_abort_r[wr_ptr_r] <= ent_abort_s;
            mem_pc_r[wr_ptr_r]    <= i_pc_ff;
            mem_pcp_r[wr_ptr_r]   <= ent_pcp_s;
            mem_pred_r[wr_ptr_r]  <= i_pred;
        end
    end

    // Head presentation, forced to zero while empty so stale entries never leak.
    always_comb begin
        o_ready        = ready_s;
        o_valid        = valid_s;
        o_count        = count_r;
        o_instruction  = 32'h0000_0000;
        o_instr_abort  = 1'b0;
        o_pc_ff        = 32'h0000_0000;
        o_pc_plus_8_ff = 32'h0000_0000;
        o_pred         = {PRED_W{1'b0}};
        if (valid_s) begin
            o_instruction  = mem_instr_r[rd_ptr_r];
            o_instr_abort  = mem_abort_r[rd_ptr_r];
            o_pc_ff        = mem_pc_r[rd_ptr_r];
            o_pc_plus_8_ff = mem_pcp_r[rd_ptr_r];
            o_pred         = mem_pred_r[rd_ptr_r];
        end else begin
            o_instruction  = 32'h0000_0000;
        end
    end

endmodule

// File: tb/tb_zap_fetch_queue.sv
// tb_zap_fetch_queue: scoreboard bench for zap_fetch_queue; honours ZAP_FETCH_QUEUE_BKPT_EN.
module tb_zap_fetch_queue;

    localparam int DEPTH  = 4;
    localparam int PRED_W = 33;
`ifdef ZAP_FETCH_QUEUE_BKPT_EN
    localparam bit BKPT_ON = 1'b1;
`else
    localparam bit BKPT_ON = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, wb_clr, dstall, alu_clr, pstall, dec_clr, t, valid, abort;
    logic [31:0]       pc, instr;
    logic [PRED_W-1:0] pred;

    logic              o_ready, o_valid, o_instr_abort;
    logic [31:0]       o_instruction, o_pc_ff, o_pc_plus_8_ff;
    logic [PRED_W-1:0] o_pred;
    logic [2:0]        o_count;

    zap_fetch_queue #(.DEPTH(DEPTH), .PRED_W(PRED_W)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_clear_from_writeback(wb_clr), .i_data_stall(dstall),
        .i_clear_from_alu(alu_clr), .i_stall_from_pipe(pstall),
        .i_clear_from_decode(dec_clr), .i_pc_ff(pc), .i_cpsr_ff_t(t),
        .i_instruction(instr), .i_valid(valid), .i_instr_abort(abort), .i_pred(pred),
        .o_ready(o_ready), .o_valid(o_valid), .o_instruction(o_instruction),
        .o_instr_abort(o_instr_abort), .o_pc_ff(o_pc_ff),
        .o_pc_plus_8_ff(o_pc_plus_8_ff), .o_pred(o_pred), .o_count(o_count)
    );

    typedef struct packed {
        logic [31:0]       instr;
        logic              abort;
        logic [31:0]       pc;
        logic [31:0]       pcp;
        logic [PRED_W-1:0] pred;
    } ent_t;

    ent_t exp_q[$];
    bit   m_sleep;
    bit   last_push;
    int   n_cmp;
    int   n_bad;

    task automatic idle();
        rst = 1'b0; wb_clr = 1'b0; dstall = 1'b0; alu_clr = 1'b0; pstall = 1'b0;
        dec_clr = 1'b0; t = 1'b0; valid = 1'b0; abort = 1'b0;
        pc = 32'h0; instr = 32'h0; pred = '0;
    endtask

    // One cycle: check status/head against the scoreboard, then apply the model for this edge.
    task automatic tick();
        ent_t e;
        ent_t h;
        bit   m_ready, m_flush, m_pop, m_push, bk;
        m_ready = (exp_q.size() != DEPTH) && !m_sleep;
        n_cmp++;
        if (o_valid !== (exp_q.size() != 0) || o_count !== 3'(exp_q.size()) || o_ready !== m_ready) begin
            n_bad++;
            $display("FAIL sb_status: got valid=%0b count=%0d ready=%0b, required valid=%0b count=%0d ready=%0b",
                     o_valid, o_count, o_ready, exp_q.size() != 0, exp_q.size(), m_ready);
        end
        if (exp_q.size() != 0) begin
            h = exp_q[0];
            n_cmp++;
            if (o_instruction !== h.instr || o_instr_abort !== h.abort || o_pc_ff !== h.pc ||
                o_pc_plus_8_ff !== h.pcp || o_pred !== h.pred) begin
                n_bad++;
                $display("FAIL sb_head: got instr=%h abort=%0b pc=%h pcp=%h pred=%h, required instr=%h abort=%0b pc=%h pcp=%h pred=%h",
                         o_instruction, o_instr_abort, o_pc_ff, o_pc_plus_8_ff, o_pred,
                         h.instr, h.abort, h.pc, h.pcp, h.pred);
            end
        end
        m_flush = wb_clr | (alu_clr & !dstall) | (dec_clr & !dstall & !pstall);
        m_pop   = (exp_q.size() != 0) && !dstall && !pstall && !m_flush;
        m_push  = valid && m_ready && !m_flush;
        e.instr = pc[1] ? {16'h0000, instr[31:16]} : instr;
        e.pc    = pc;
        e.pcp   = t ? pc + 32'd4 : pc + 32'd8;
        e.pred  = pred;
        if (t) bk = ((pc[1] ? instr[31:24] : instr[15:8]) == 8'hBE);
        else   bk = ((instr & 32'h0FF0_00F0) == 32'h0120_0070);
        e.abort = abort | (bk & BKPT_ON);
        if (rst || m_flush) begin
            exp_q.delete();
            m_sleep = 1'b0;
        end else begin
            if (m_pop) void'(exp_q.pop_front());
            if (m_push) begin
                exp_q.push_back(e);
                if (e.abort) m_sleep = 1'b1;
            end
        end
        last_push = m_push && !rst;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({o_valid, o_instruction, o_instr_abort, o_pc_ff, o_pc_plus_8_ff, o_pred, o_count} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got valid=%0b instr=%h pc=%h count=%0d, required all zero",
                     o_valid, o_instruction, o_pc_ff, o_count);
        end
        exp_q.delete();
        m_sleep = 1'b0;
        rst = 1'b0;
        tick();
        n_cmp++;
        if (o_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_ready: got %0b, required 1", o_ready);
        end
    endtask

    task automatic test_in_order();
        int peak;
        peak = 0;
        for (int i = 0; i < 4; i++) begin
            valid = 1'b1; t = 1'b0;
            pc    = 32'h100 + 32'(4 * i);
            instr = 32'hA000_0000 | 32'(i);
            pred  = {1'b1, 32'(i)};
            tick();
            if (int'(o_count) > peak) peak = int'(o_count);
            if (i == 0) begin
                n_cmp++;
                if (o_valid !== 1'b1 || o_pc_plus_8_ff !== 32'h108) begin
                    n_bad++;
                    $display("FAIL first_word: got valid=%0b pcp=%h, required valid=1 pcp=00000108",
                             o_valid, o_pc_plus_8_ff);
                end
            end
        end
        valid = 1'b0;
        tick();
        n_cmp++;
        if (peak != 1) begin
            n_bad++;
            $display("FAIL count_peak: got %0d, required 1", peak);
        end
    endtask

    task automatic test_stall_fill();
        pstall = 1'b1; valid = 1'b1; t = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pc    = 32'h400 + 32'(4 * i);
            instr = 32'hB000_0000 | 32'(i);
            pred  = 33'(i + 16);
            tick();
        end
        n_cmp++;
        if (o_count !== 3'd4 || o_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL full_hold: got count=%0d ready=%0b, required count=4 ready=0", o_count, o_ready);
        end
        pstall = 1'b0;
        tick();
        n_cmp++;
        if (o_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL ready_after_pop: got %0b, required 1", o_ready);
        end
        for (int k = 0; k < 10 && !last_push; k++) tick();
        valid = 1'b0;
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) tick();
        n_cmp++;
        if (o_count !== 3'd0 || o_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_drain: got count=%0d valid=%0b, required count=0 valid=0", o_count, o_valid);
        end
    endtask

    task automatic test_compressed();
        t = 1'b1; valid = 1'b1;
        pc = 32'h202; instr = 32'hABCD_1234; pred = 33'h1_0000_0202;
        tick();
        pc = 32'h204; instr = 32'h5555_6666; pred = 33'h0_0000_0204;
        n_cmp++;
        if (o_instruction !== 32'h0000_ABCD || o_pc_plus_8_ff !== 32'h206) begin
            n_bad++;
            $display("FAIL compressed_hi: got instr=%h pcp=%h, required instr=0000abcd pcp=00000206",
                     o_instruction, o_pc_plus_8_ff);
        end
        tick();
        valid = 1'b0;
        tick();
        t = 1'b0;
    endtask

    task automatic test_abort_sleep();
        pstall = 1'b1; valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pc    = 32'h500 + 32'(4 * i);
            instr = 32'hC000_0000 | 32'(i);
            pred  = 33'(i + 40);
            abort = (i == 2);
            tick();
        end
        abort = 1'b0;
        n_cmp++;
        if (o_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL sleep_ready: got %0b, required 0", o_ready);
        end
        pc = 32'h50C; instr = 32'hC000_0003; pstall = 1'b0;
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) tick();
        valid = 1'b0;
        n_cmp++;
        if (o_valid !== 1'b0 || o_ready !== 1'b0 || o_count !== 3'd0) begin
            n_bad++;
            $display("FAIL sleep_drain: got valid=%0b ready=%0b count=%0d, required 0 0 0",
                     o_valid, o_ready, o_count);
        end
        alu_clr = 1'b1;
        tick();
        alu_clr = 1'b0;
        n_cmp++;
        if (o_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL wake_on_clear: got %0b, required 1", o_ready);
        end
    endtask

    task automatic test_masked_clear();
        pstall = 1'b1; valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pc    = 32'h600 + 32'(4 * i);
            instr = 32'hD000_0000 | 32'(i);
            pred  = 33'(i + 60);
            tick();
        end
        valid = 1'b0; alu_clr = 1'b1; dec_clr = 1'b1; dstall = 1'b1;
        tick();
        alu_clr = 1'b0; dec_clr = 1'b0;
        n_cmp++;
        if (o_count !== 3'd3) begin
            n_bad++;
            $display("FAIL masked_clear: got count=%0d, required 3", o_count);
        end
        wb_clr = 1'b1; valid = 1'b1; pc = 32'h700; instr = 32'hD000_0007;
        tick();
        wb_clr = 1'b0; valid = 1'b0; dstall = 1'b0; pstall = 1'b0;
        n_cmp++;
        if (o_count !== 3'd0 || o_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL wb_flush: got count=%0d valid=%0b, required 0 0", o_count, o_valid);
        end
        tick();
        n_cmp++;
        if (o_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_drop: got valid=%0b, required 0", o_valid);
        end
    endtask

    task automatic test_bkpt();
        t = 1'b0; valid = 1'b1;
        pc = 32'h300; instr = 32'hE120_0070; pred = 33'h0_0000_0300;
        tick();
        valid = 1'b0;
        n_cmp++;
        if (o_instr_abort !== BKPT_ON || o_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL bkpt_abort: got abort=%0b valid=%0b, required abort=%0b valid=1",
                     o_instr_abort, o_valid, BKPT_ON);
        end
        tick();
        n_cmp++;
        if (o_ready !== !BKPT_ON) begin
            n_bad++;
            $display("FAIL bkpt_sleep: got ready=%0b, required %0b", o_ready, !BKPT_ON);
        end
        wb_clr = 1'b1;
        tick();
        wb_clr = 1'b0;
        tick();
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; m_sleep = 1'b0; last_push = 1'b0;
        idle();
        @(negedge clk);
        test_reset();
        test_in_order();
        test_stall_fill();
        test_compressed();
        test_abort_sleep();
        test_masked_clear();
        test_bkpt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
